// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises reset and clock lock, holds all channels, then releases them in order.
// Build option RST_SEQ_STAGGER_EN: staggered per-channel release; otherwise all channels release together.
module reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int N_CH           = 4,
  parameter int STAGGER_CYCLES = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_lock,
  output logic [N_CH-1:0] o_rst,
  output logic            o_done,
  output logic [1:0]      o_state
);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || HOLD_CYCLES < 1 || HOLD_CYCLES > 65535 ||
      N_CH < 1 || N_CH > 16 || STAGGER_CYCLES < 1 || STAGGER_CYCLES > 255) begin : g_param_check
    $error("reset_sequencer: parameter out of legal range");
  end

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] rst_chain;
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] lock_chain;

  logic rst_sync;
  logic lock_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rst_chain  <= '1;
      lock_chain <= '0;
    end else begin
      rst_chain  <= {rst_chain[SYNC_STAGES-2:0], 1'b0};
      lock_chain <= {lock_chain[SYNC_STAGES-2:0], i_lock};
    end
  end

  assign rst_sync  = rst_chain[SYNC_STAGES-1];
  assign lock_sync = lock_chain[SYNC_STAGES-1];

  state_t          state;
  logic [N_CH-1:0] rst_r;
  logic            done_r;
  logic [15:0]     hold_cnt;
`ifdef RST_SEQ_STAGGER_EN
  localparam logic [7:0] STAG_LAST = 8'(STAGGER_CYCLES - 1);
  localparam logic [4:0] CH_LAST   = 5'(N_CH - 1);
  logic [7:0] stag_cnt;
  logic [4:0] ch_idx;
`endif

  // Leaving ASSERT requires clean reset and lock; any later lock loss restarts from scratch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_ASSERT;
      rst_r    <= '1;
      done_r   <= 1'b0;
      hold_cnt <= '0;
`ifdef RST_SEQ_STAGGER_EN
      stag_cnt <= '0;
      ch_idx   <= '0;
`endif
    end else if (state != ST_ASSERT && (rst_sync || !lock_sync)) begin
      state    <= ST_ASSERT;
      rst_r    <= '1;
      done_r   <= 1'b0;
      hold_cnt <= '0;
`ifdef RST_SEQ_STAGGER_EN
      stag_cnt <= '0;
      ch_idx   <= '0;
`endif
    end else begin
      case (state)
        ST_ASSERT: begin
          if (!rst_sync && lock_sync) state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
`ifdef RST_SEQ_STAGGER_EN
            rst_r <= rst_r << 1;
            if (N_CH == 1) begin
              state  <= ST_RUN;
              done_r <= 1'b1;
            end else begin
              state    <= ST_RELEASE;
              stag_cnt <= '0;
              ch_idx   <= 5'd1;
            end
`else
            rst_r  <= '0;
            state  <= ST_RUN;
            done_r <= 1'b1;
`endif
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        ST_RELEASE: begin
`ifdef RST_SEQ_STAGGER_EN
          // Zeros shift in from bit 0, so released channels can never re-assert here.
          if (stag_cnt == STAG_LAST) begin
            stag_cnt <= '0;
            rst_r    <= rst_r << 1;
            if (ch_idx == CH_LAST) begin
              state  <= ST_RUN;
              done_r <= 1'b1;
            end else begin
              ch_idx <= ch_idx + 5'd1;
            end
          end else begin
            stag_cnt <= stag_cnt + 8'd1;
          end
`else
          state <= ST_ASSERT;
          rst_r <= '1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign o_rst   = rst_r;
  assign o_done  = done_r;
  assign o_state = state;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2, synchroniser depth for the reset and lock chains; legal range 2..4.
REQ-002 Parameter HOLD_CYCLES, default 16, minimum clocks all outputs stay asserted after reset and lock are both clean; legal range 1..65535.
REQ-003 Parameter N_CH, default 4, number of reset output channels; legal range 1..16.
REQ-004 Parameter STAGGER_CYCLES, default 8, clocks between successive channel releases; legal range 1..255.
REQ-005 i_clk  input  1  clock; reset i_rst, asynchronous, active-high.
REQ-006 i_rst  input  1  asynchronous active-high reset request.
REQ-007 i_lock  input  1  asynchronous clock-source lock indication; 1 = clock valid.
REQ-008 o_rst  output  N_CH  per-channel active-high reset; bit 0 releases first.
REQ-009 o_done  output  1  high when every channel is released.
REQ-010 o_state  output  2  current FSM state encoding: ASSERT=0, HOLD=1, RELEASE=2, RUN=3.

Function
REQ-011 Reset and lock SHALL each pass through a SYNC_STAGES-deep flop chain marked ASYNC_REG; the reset chain presets to 1 and the lock chain clears to 0 on i_rst.
REQ-012 ASSERT: all o_rst high; go to HOLD on the edge where synchronised reset is 0 and synchronised lock is 1.
REQ-013 HOLD: hold counter increments each edge; go to RELEASE after exactly HOLD_CYCLES edges in HOLD.
REQ-014 RELEASE: o_rst[0] SHALL deassert on the edge leaving HOLD; o_rst[k] SHALL deassert exactly k*STAGGER_CYCLES edges after o_rst[0].
REQ-015 Release is monotonic: a released channel stays low until a return to ASSERT.
REQ-016 Go to RUN on the edge that releases o_rst[N_CH-1]; o_done rises on that same edge.
REQ-017 With i_rst low and i_lock steady high from before i_rst falls, o_rst[0] SHALL deassert on edge SYNC_STAGES+HOLD_CYCLES+1, counting the first rising edge after i_rst falls as edge 1.
REQ-018 Synchronised lock at 0 in HOLD, RELEASE or RUN: go to ASSERT on the next edge. On that edge, reassert all o_rst, clear o_done and clear all counters.
REQ-019 After a lock loss, the full HOLD_CYCLES SHALL be served again before any release; no partial credit.
REQ-020 Lock glitch shorter than one clock: the only required behaviour is that outputs never release early. Whether the glitch is caught is not specified.
REQ-021 Counters SHALL be sized to the parameter maxima with no wrap-around in any state.
REQ-022 With N_CH=1, RELEASE lasts zero cycles: HOLD goes directly to RUN on the edge that releases o_rst[0].

Reset
REQ-023 i_rst high SHALL immediately, without a clock edge, force o_rst to all ones, o_done to 0, o_state to ASSERT, counters to 0 and the reset chain to all ones.
REQ-024 i_rst asserted mid-RELEASE or mid-HOLD SHALL behave identically to reset from RUN.
REQ-025 o_rst de-assertion SHALL only ever occur synchronous to a rising i_clk edge.
REQ-026 Power-up initial values SHALL equal the reset values.

Configuration
REQ-027 Macro RST_SEQ_STAGGER_EN defined: staggered release per REQ-014.
REQ-028 Macro RST_SEQ_STAGGER_EN undefined: STAGGER_CYCLES is ignored. All o_rst bits deassert together on the edge leaving HOLD, and the FSM enters RUN on that same edge. RELEASE state is unreachable, but its encoding is retained.

Verification
REQ-029 Defaults with macro defined, i_lock=1, i_rst pulse then low -> o_rst[0..3] fall on edges 19/27/35/43; o_done rises on edge 43.
REQ-030 Defaults with macro undefined, same stimulus -> o_rst goes 4'hF to 4'h0 on edge 19; o_done rises on edge 19.
REQ-031 i_lock drops for 3 clocks at edge 30 (defaults, macro defined) -> o_rst=4'hF and o_state=0 within SYNC_STAGES+1 edges. After lock returns, o_rst[0] falls SYNC_STAGES+HOLD_CYCLES+1 edges later.
REQ-032 i_rst asserted between clock edges during RELEASE -> o_rst=4'hF and o_done=0 before the next edge. On deassertion, the full sequence repeats per REQ-029.
REQ-033 i_lock held low 100 clocks after reset -> o_rst stays 4'hF and o_state=0 throughout; release timing counts from the lock rise.
REQ-034 N_CH=1, HOLD_CYCLES=1 -> o_rst[0] and o_done change on edge SYNC_STAGES+2 = 4.
